booth_mul_sequencer: RTL and testbench
======================================

# booth_mul_sequencer

Upstream operand sequencer for the team's 4-bit Booth multiplier.
- Buffers signed operand pairs in a small FIFO and drives the multiplier's start/a/b pins, holding `start` high for a fixed latency window.
- Captures the 8-bit product and keeps a running signed sum.
- Presents each product and the updated sum through a valid/ready output handshake.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `MUL_LAT`, 8: cycles `mul_start` is held high per operation; ≥2.
- `ACC_W`, 12: accumulator width, ≥8.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a` in 4: signed multiplicand.
- `in_b` in 4: signed multiplier.
- `clr_acc` in 1: synchronous accumulator clear.
- `mul_start` out 1: to multiplier `start`.
- `mul_a` out 4: to multiplier `a`.
- `mul_b` out 4: to multiplier `b`.
- `mul_p` in 8: signed product from multiplier `p`.
- `out_valid` out 1: product/sum valid.
- `out_ready` in 1: consumer accepts.
- `out_p` out 8: captured signed product.
- `out_acc` out ACC_W: signed running sum including `out_p`.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- Push when `in_valid && in_ready`; `in_ready = !full`. Push and pop in the same cycle are allowed whenever the FIFO is non-empty.
- FSM states:
  - **IDLE**: if the FIFO is non-empty, pop the head, register it into `mul_a`/`mul_b`, set `mul_start=1`, `cnt=0`, and go to RUN. Otherwise stay.
  - **RUN**: `cnt` increments each cycle. On the cycle with `cnt==MUL_LAT-1`:
    - register `mul_p` into `out_p`;
    - set `acc <= acc + sext(mul_p)`, wrapping two's complement at `ACC_W`;
    - set `mul_start=0`, `out_valid=1`;
    - go to HOLD.
  - **HOLD**: `out_valid` stays high, and `out_p`/`out_acc` stay stable, until `out_ready`. On acceptance, clear `out_valid` and go to IDLE.
- `mul_a`/`mul_b` remain stable from the IDLE pop until the next pop; they are never changed while `mul_start=1`.
- `mul_start` is low for at least 2 cycles between operations (HOLD ≥1 cycle plus IDLE 1 cycle). This guarantees the multiplier sees a fresh rising edge of `start`.
- `out_acc` mirrors `acc`.
- `clr_acc`:
  - Zeroes `acc` the next cycle.
  - If it coincides with the RUN capture cycle, `acc <= sext(mul_p)` (clear first, then add).
  - In HOLD it changes `out_acc` while `out_valid` is high. This is the only permitted change, and it is the caller's responsibility.
- Reset (any state, including mid-RUN) asynchronously:
  - empties the FIFO;
  - sets FSM to IDLE and `cnt=0`;
  - zeroes `mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_p`, `acc`;
  - sets `in_ready=1` and `busy=0`.
  
  An in-flight product is discarded.

## Timing
- A pair pushed into an empty FIFO while the FSM is in IDLE at edge N:
  - pops at edge N+1, with `mul_start` high from N+1;
  - is captured at edge N+MUL_LAT+1, with `out_valid` high from that edge.
- `mul_start` is high for exactly MUL_LAT cycles.
- Product sampling happens on the last edge of the high window, so the multiplier must settle within MUL_LAT-1 cycles of `start` rising.
- Peak throughput is one product per MUL_LAT+2 cycles with `out_ready` tied high.
- Output backpressure stalls the FSM in HOLD. The FIFO keeps accepting until full.
- `cnt` width is `$clog2(MUL_LAT)`. FIFO pointers carry one extra wrap bit for full/empty detection.

## Structure
- Package `booth_seq_pkg`:
  - state enum {IDLE, RUN, HOLD};
  - operand width 4 and product width 8 constants;
  - a packed operand-pair struct {a, b}.
- One sub-module, `booth_op_fifo`: a synchronous DEPTH-entry FIFO with push/pop/full/empty and the same async reset.
- FSM, counter and accumulator live in the top module.

## Test plan
- Reset check: assert `rst_n=0` mid-simulation. Required: all outputs at their reset values, `in_ready=1`. After release, no `mul_start` without a push.
- Single ops, with the real multiplier attached, `out_ready=1`, pushing (-1,2), (3,2), (3,-6), (-5,-6):
  - `out_p` = 0xFE, 0x06, 0xEE, 0x1E;
  - `out_acc` = -2, 4, -14, 16;
  - `mul_start` high exactly 8 cycles each, with ≥2 low cycles between.
- Burst/full: push 5 pairs back-to-back with `out_ready=0`.
  - `in_ready` drops after the 4th queued entry.
  - The FSM sits in HOLD with the first product.
  - Releasing `out_ready` drains all 5 in order.
- Backpressure: hold `out_ready=0` for 20 cycles in HOLD. `out_p`/`out_acc` stay stable and `mul_start` stays low.
- `clr_acc` collision: accumulate 16, then assert `clr_acc` on the capture cycle of (2,3). Required `out_acc`=6. `clr_acc` in IDLE gives 0.
- Reset mid-RUN: at `cnt`=3, pulse `rst_n` low.
  - No `out_valid` for the aborted op.
  - FIFO empty.
  - The next push produces a correct product with `acc` starting at 0.

Source files
------------

// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg: shared types and widths for the Booth multiplier operand sequencer
package booth_seq_pkg;
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;
endpackage

// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: operand input and product/sum output handshakes
interface booth_mul_sequencer_if #(parameter int ACC_W = 12);
    import booth_seq_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_p;
    logic [ACC_W-1:0]  out_acc;

    modport master (output in_valid, in_a, in_b, out_ready,
                    input  in_ready, out_valid, out_p, out_acc);
    modport slave  (input  in_valid, in_a, in_b, out_ready,
                    output in_ready, out_valid, out_p, out_acc);
endinterface

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: DEPTH-entry operand-pair FIFO, pointers carry a wrap bit for full/empty
module booth_op_fifo
    import booth_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  op_pair_t din,
    input  logic     pop,
    output op_pair_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    op_pair_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // storage needs no reset; emptiness is tracked purely by the pointers
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;

    // advance write/read pointers on accepted push/pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: feeds queued operand pairs to the Booth multiplier and accumulates products
module booth_mul_sequencer
    import booth_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 8,
    parameter int ACC_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_acc,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              busy,
    booth_mul_sequencer_if.slave io
);
    localparam int CNT_W = $clog2(MUL_LAT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              out_valid;
    logic [PROD_W-1:0] out_p;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  p_ext;
    op_pair_t          head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              cap;

    assign pop   = (state == IDLE) && !empty;
    assign cap   = (state == RUN) && (cnt == CNT_W'(MUL_LAT - 1));
    assign p_ext = ACC_W'($signed(mul_p));

    assign io.in_ready  = !full;
    assign io.out_valid = out_valid;
    assign io.out_p     = out_p;
    assign io.out_acc   = acc;
    assign busy         = (state != IDLE) || !empty;

    booth_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (io.in_valid),
        .din   (op_pair_t'{a: io.in_a, b: io.in_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // sequencing FSM: pop into mul_a/mul_b, hold start for MUL_LAT cycles, present result until accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    mul_a     <= head.a;
                    mul_b     <= head.b;
                    mul_start <= 1'b1;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cap) begin
                        out_p     <= mul_p;
                        mul_start <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (io.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

    // running signed sum; a clear on the capture cycle applies before the add
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc <= '0;
        else        acc <= clr_acc ? (cap ? p_ext : '0) : (cap ? acc + p_ext : acc);
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: directed checks of sequencing, accumulation, backpressure and reset
module tb_booth_mul_sequencer;
    import booth_seq_pkg::*;
    localparam int ACC_W = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_acc = 1'b0;
    logic       mul_start;
    logic       busy;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_p;
    logic [3:0] mc = '0;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    logic signed [7:0] prod;
    int vectors = 0;
    int miscompares = 0;
    int hi = 0;
    int lo = 99;
    int k;

    booth_mul_sequencer_if #(.ACC_W(ACC_W)) io ();

    booth_mul_sequencer #(.DEPTH(4), .MUL_LAT(8), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_acc   (clr_acc),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy),
        .io        (io)
    );

    always #5 clk = ~clk;

    // multiplier model: product is only valid 7 cycles after start rises, garbage otherwise
    assign ea    = {{4{mul_a[3]}}, mul_a};
    assign eb    = {{4{mul_b[3]}}, mul_b};
    assign prod  = ea * eb;
    assign mul_p = (mul_start && mc >= 4'd7) ? prod : 8'hA5;
    always @(posedge clk) mc <= mul_start ? mc + 4'd1 : 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // start pulse width must be exactly 8 cycles, with at least 2 low cycles between pulses
    always @(negedge clk or negedge rst_n)
        if (!rst_n) begin
            hi = 0;
            lo = 99;
        end else if (mul_start === 1'b1) begin
            if (hi == 0) check("start_gap", 32'(lo >= 2), 32'd1);
            hi++;
            lo = 0;
        end else begin
            if (hi != 0) check("start_width", 32'(hi), 32'd8);
            hi = 0;
            lo++;
        end

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        check("in_ready_push", 32'(io.in_ready), 32'd1);
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (io.out_valid !== 1'b1 && n < 60);
        check("out_valid_timeout", 32'(io.out_valid), 32'd1);
    endtask

    task automatic result(input logic [7:0] p, input logic [11:0] acc);
        check("out_p", 32'(io.out_p), 32'(p));
        check("out_acc", 32'(io.out_acc), 32'(acc));
    endtask

    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p, input logic [11:0] acc);
        int n;
        push(a, b);
        wait_out(n);
        check("latency", 32'(n), 32'd10);
        result(p, acc);
    endtask

    task automatic reset_values();
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_out_p", 32'(io.out_p), 32'd0);
        check("rst_out_acc", 32'(io.out_acc), 32'd0);
        check("rst_in_ready", 32'(io.in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_values();
        @(negedge clk) rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_no_start", 32'(mul_start), 32'd0);
        end

        op(4'hF, 4'h2, 8'hFE, 12'hFFE);
        op(4'h3, 4'h2, 8'h06, 12'h004);
        op(4'h3, 4'hA, 8'hEE, 12'hFF2);
        op(4'hB, 4'hA, 8'h1E, 12'h010);

        @(posedge clk);
        #1 io.out_ready = 1'b0;
        push(4'h1, 4'h1);
        push(4'h2, 4'h2);
        push(4'hD, 4'h3);
        push(4'h7, 4'h8);
        push(4'h8, 4'h8);
        @(negedge clk);
        check("full_in_ready", 32'(io.in_ready), 32'd0);
        wait_out(k);
        result(8'h01, 12'h011);
        check("hold_busy", 32'(busy), 32'd1);
        repeat (20) begin
            @(negedge clk);
            check("hold_valid", 32'(io.out_valid), 32'd1);
            check("hold_p", 32'(io.out_p), 32'h01);
            check("hold_acc", 32'(io.out_acc), 32'h011);
            check("hold_start", 32'(mul_start), 32'd0);
        end
        io.out_ready = 1'b1;
        wait_out(k);
        result(8'h04, 12'h015);
        wait_out(k);
        result(8'hF7, 12'h00C);
        wait_out(k);
        result(8'hC8, 12'hFD4);
        wait_out(k);
        result(8'h40, 12'h014);
        repeat (3) @(negedge clk);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_in_ready", 32'(io.in_ready), 32'd1);

        clr_acc = 1'b1;
        @(negedge clk) clr_acc = 1'b0;
        check("clr_idle_acc", 32'(io.out_acc), 32'd0);
        op(4'h4, 4'h4, 8'h10, 12'h010);
        push(4'h2, 4'h3);
        repeat (8) @(posedge clk);
        #1 clr_acc = 1'b1;
        @(posedge clk);
        #1 clr_acc = 1'b0;
        wait_out(k);
        check("clr_cap_latency", 32'(k), 32'd1);
        result(8'h06, 12'h006);

        push(4'h5, 4'h5);
        push(4'h6, 4'h1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_values();
        @(negedge clk) rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("abort_valid", 32'(io.out_valid), 32'd0);
            check("abort_start", 32'(mul_start), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
        end
        op(4'hE, 4'h3, 8'hFA, 12'hFFA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
